// File: rtl/ddr_wr_burst_ctrl_pkg.sv
// Shared types and widths for the DDR write-burst controller: FSM states,
// DDR user-port address/length/data widths and the frame base-address helper.
package ddr_wr_burst_ctrl_pkg;

  localparam int DDR_ADDR_W = 28;
  localparam int DDR_LEN_W  = 7;
  localparam int DDR_DATA_W = 128;
  localparam int FIFO_LVL_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Word address of the first word of frame buffer idx.
  function automatic logic [DDR_ADDR_W-1:0] frame_base(
    input logic [DDR_ADDR_W-1:0] base,
    input logic [1:0]            idx,
    input logic [DDR_ADDR_W-1:0] frame_words
  );
    return base + DDR_ADDR_W'(idx) * frame_words;
  endfunction

endpackage

// File: rtl/ddr_wr_burst_ctrl_if.sv
// DDR user-port write channel: burst command handshake plus write-data handshake.
interface ddr_wr_burst_ctrl_if;
  import ddr_wr_burst_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DDR_ADDR_W-1:0] cmd_addr;
  logic [DDR_LEN_W-1:0]  cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DDR_DATA_W-1:0] wdata;
  logic                  wdata_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last,
    input  cmd_ready, wdata_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last,
    output cmd_ready, wdata_ready
  );

endinterface

// File: rtl/ddr_wr_skid_buf.sv
// Two-entry 128-bit skid buffer that absorbs the one-cycle FIFO read latency
// between the FIFO read port and the DDR write-data handshake.
module ddr_wr_skid_buf
  import ddr_wr_burst_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DDR_DATA_W-1:0] push_data,
  input  logic                  pop,
  output logic [DDR_DATA_W-1:0] head_data,
  output logic [1:0]            count
);

  logic [DDR_DATA_W-1:0] mem_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Moves video frames from a FIFO into rotating DDR frame buffers as bursts.
// Define DDR_WR_BURST_STAT_EN to add the burst_cnt / frame_drop statistics outputs.
module ddr_wr_burst_ctrl
  import ddr_wr_burst_ctrl_pkg::*;
#(
  parameter int                    BURST_LEN   = 16,
  parameter int                    FRAME_WORDS = 115200,
  parameter logic [DDR_ADDR_W-1:0] BASE_ADDR   = 28'h0,
  parameter int                    NUM_BUFS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [FIFO_LVL_W-1:0] fifo_rd_water_level,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  input  logic [DDR_DATA_W-1:0] fifo_rd_data,
  ddr_wr_burst_ctrl_if.master   ddr,
  output logic                  busy,
  output logic [1:0]            buf_idx
`ifdef DDR_WR_BURST_STAT_EN
  ,
  output logic [15:0]           burst_cnt,
  output logic                  frame_drop
`endif
);

  localparam int OFS_W_RAW = $clog2(FRAME_WORDS + 1);
  localparam int OFS_W     = (OFS_W_RAW > DDR_LEN_W) ? OFS_W_RAW : DDR_LEN_W + 1;

  state_t                state_reg, state_next;
  logic [OFS_W-1:0]      word_ofs_reg, word_ofs_next;
  logic [OFS_W-1:0]      words_left_reg, words_left_next;
  logic [1:0]            buf_idx_reg, buf_idx_next;
  logic                  fs_pending_reg, fs_pending_next;
  logic [DDR_LEN_W-1:0]  rd_cnt_reg;
  logic [DDR_LEN_W-1:0]  beat_cnt_reg;
  logic                  inflight_reg;

  logic [DDR_LEN_W-1:0]  blen;
  logic                  fs_eff;
  logic                  burst_ready;
  logic                  wvalid;
  logic                  wlast;
  logic                  beat_fire;
  logic                  rd_en;
  logic [1:0]            skid_count;
  logic [1:0]            occ_after;
  logic [DDR_DATA_W-1:0] skid_head;

  // Burst length is fixed for the whole CMD/DATA episode because words_left only moves at burst end.
  assign blen = (words_left_reg >= OFS_W'(BURST_LEN)) ? DDR_LEN_W'(BURST_LEN)
                                                      : words_left_reg[DDR_LEN_W-1:0];

  assign fs_eff      = frame_start || fs_pending_reg;
  assign burst_ready = (words_left_reg != '0) &&
                       (fifo_rd_water_level >= FIFO_LVL_W'(blen));

  assign wvalid    = (state_reg == DATA) && (skid_count != 2'd0);
  assign wlast     = wvalid && (beat_cnt_reg == blen - 7'd1);
  assign beat_fire = wvalid && ddr.wdata_ready;

  // Occupancy is counted after this cycle's pop so back-to-back beats keep one read in flight.
  assign occ_after = skid_count - {1'b0, beat_fire} + {1'b0, inflight_reg};
  assign rd_en     = (state_reg == DATA) && (occ_after < 2'd2) &&
                     (rd_cnt_reg < blen) && !fifo_rd_empty;

  ddr_wr_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_rd_data),
    .pop       (beat_fire),
    .head_data (skid_head),
    .count     (skid_count)
  );

  always_comb begin
    state_next      = state_reg;
    word_ofs_next   = word_ofs_reg;
    words_left_next = words_left_reg;
    buf_idx_next    = buf_idx_reg;
    fs_pending_next = fs_pending_reg;
    case (state_reg)
      IDLE: begin
        if (fs_eff) begin
          word_ofs_next   = '0;
          words_left_next = OFS_W'(FRAME_WORDS);
          buf_idx_next    = (buf_idx_reg == 2'(NUM_BUFS - 1)) ? 2'd0 : buf_idx_reg + 2'd1;
          fs_pending_next = 1'b0;
        end else if (burst_ready) begin
          state_next = CMD;
        end
      end
      CMD: begin
        if (frame_start) fs_pending_next = 1'b1;
        if (ddr.cmd_ready) state_next = DATA;
      end
      DATA: begin
        if (frame_start) fs_pending_next = 1'b1;
        if (beat_fire && wlast) begin
          state_next      = IDLE;
          word_ofs_next   = word_ofs_reg + OFS_W'(blen);
          words_left_next = words_left_reg - OFS_W'(blen);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      word_ofs_reg   <= '0;
      words_left_reg <= '0;
      buf_idx_reg    <= 2'd0;
      fs_pending_reg <= 1'b0;
      rd_cnt_reg     <= '0;
      beat_cnt_reg   <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_ofs_reg   <= word_ofs_next;
      words_left_reg <= words_left_next;
      buf_idx_reg    <= buf_idx_next;
      fs_pending_reg <= fs_pending_next;
      inflight_reg   <= rd_en;
      if (state_reg != DATA) begin
        rd_cnt_reg   <= '0;
        beat_cnt_reg <= '0;
      end else begin
        if (rd_en)     rd_cnt_reg   <= rd_cnt_reg + 7'd1;
        if (beat_fire) beat_cnt_reg <= beat_cnt_reg + 7'd1;
      end
    end
  end

  assign ddr.cmd_valid   = (state_reg == CMD);
  assign ddr.cmd_addr    = (state_reg == CMD)
                         ? frame_base(BASE_ADDR, buf_idx_reg, DDR_ADDR_W'(FRAME_WORDS)) +
                           DDR_ADDR_W'(word_ofs_reg)
                         : '0;
  assign ddr.cmd_len     = (state_reg == CMD) ? blen - 7'd1 : '0;
  assign ddr.wdata_valid = wvalid;
  assign ddr.wdata       = wvalid ? skid_head : '0;
  assign ddr.wdata_last  = wlast;
  assign fifo_rd_en      = rd_en;
  assign busy            = (state_reg != IDLE);
  assign buf_idx         = buf_idx_reg;

`ifdef DDR_WR_BURST_STAT_EN
  logic [15:0] burst_cnt_reg;
  logic        frame_drop_reg;
  logic        drop_now;

  assign drop_now = (state_reg == IDLE) && fs_eff && (words_left_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_reg  <= 16'd0;
      frame_drop_reg <= 1'b0;
    end else begin
      if (beat_fire && wlast) burst_cnt_reg <= burst_cnt_reg + 16'd1;
      frame_drop_reg <= drop_now;
    end
  end

  assign burst_cnt  = burst_cnt_reg;
  assign frame_drop = frame_drop_reg;
`endif

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Directed bench for ddr_wr_burst_ctrl (FRAME_WORDS=40, BURST_LEN=16): a vector
// table of bursts plus hand sequences for mid-burst frame_start and reset.
module tb_ddr_wr_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [11:0]  fifo_level = 12'd0;
  logic         fifo_rd_empty;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data = '0;
  logic         busy;
  logic [1:0]   buf_idx;
`ifdef DDR_WR_BURST_STAT_EN
  logic [15:0]  burst_cnt;
  logic         frame_drop;
  int           drop_cnt = 0;
`endif

  ddr_wr_burst_ctrl_if ddr_if ();

  ddr_wr_burst_ctrl #(
    .BURST_LEN   (16),
    .FRAME_WORDS (40),
    .BASE_ADDR   (28'h0),
    .NUM_BUFS    (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_start         (frame_start),
    .fifo_rd_water_level (fifo_level),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .ddr                 (ddr_if),
    .busy                (busy),
    .buf_idx             (buf_idx)
`ifdef DDR_WR_BURST_STAT_EN
    ,
    .burst_cnt           (burst_cnt),
    .frame_drop          (frame_drop)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_rd_empty = (fifo_level == 12'd0);

  function automatic logic [127:0] mk_word(input int unsigned n);
    return {n ^ 32'hDEADBEEF, ~n, n + 32'h1000, n};
  endfunction

  // FIFO model: data appears the cycle after a read enable.
  int unsigned fifo_ptr = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mk_word(fifo_ptr);
      fifo_ptr     <= fifo_ptr + 1;
    end
  end

  // Reads issued minus beats accepted bounds skid occupancy plus the in-flight read.
  int rd_iss = 0;
  int acc    = 0;
  bit occ_bad = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      rd_iss <= 0;
      acc    <= 0;
    end else begin
      if (fifo_rd_en) rd_iss <= rd_iss + 1;
      if (ddr_if.wdata_valid && ddr_if.wdata_ready) acc <= acc + 1;
    end
  end
  always @(negedge clk) begin
    if (rd_iss - acc > 2) occ_bad = 1'b1;
`ifdef DDR_WR_BURST_STAT_EN
    if (frame_drop) drop_cnt = drop_cnt + 1;
`endif
  end

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_seq = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic expect_no_cmd(input int ncyc, input int exp_buf);
    bit seen;
    seen = 1'b0;
    ddr_if.cmd_ready = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (ddr_if.cmd_valid || busy) seen = 1'b1;
    end
    check("no_cmd_idle", 128'(seen), 128'(0));
    check("idle_buf_idx", 128'(buf_idx), 128'(exp_buf));
    $display("idle window %0d cycles buf=%0d", ncyc, buf_idx);
  endtask

  task automatic run_burst(input bit toggle, input int cmd_delay, input int exp_addr,
                           input int exp_len, input int exp_buf, input int fs_beat);
    int cyc, beats, first_c, last_c;
    bit stable_ok, data_ok, last_ok, hold_ok, held_v, fs_pend;
    logic [27:0]  a0;
    logic [6:0]   l0;
    logic [127:0] held;
    ddr_if.cmd_ready   = 1'b0;
    ddr_if.wdata_ready = 1'b0;
    cyc = 0;
    #1;
    while (!ddr_if.cmd_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("cmd_valid_seen", 128'(ddr_if.cmd_valid), 128'(1));
    if (!ddr_if.cmd_valid) return;
    a0 = ddr_if.cmd_addr;
    l0 = ddr_if.cmd_len;
    stable_ok = 1'b1;
    for (int i = 0; i < cmd_delay; i++) begin
      tick();
      if (!ddr_if.cmd_valid || ddr_if.cmd_addr != a0 || ddr_if.cmd_len != l0) stable_ok = 1'b0;
    end
    if (cmd_delay > 0) check("cmd_hold_stable", 128'(stable_ok), 128'(1));
    check("cmd_addr", 128'(ddr_if.cmd_addr), 128'(exp_addr));
    check("cmd_len", 128'(ddr_if.cmd_len), 128'(exp_len));
    check("cmd_buf_idx", 128'(buf_idx), 128'(exp_buf));
    ddr_if.cmd_ready = 1'b1;
    tick();
    ddr_if.cmd_ready = 1'b0;

    beats = 0; cyc = 0; first_c = -1; last_c = -1;
    data_ok = 1'b1; last_ok = 1'b1; hold_ok = 1'b1; held_v = 1'b0; fs_pend = 1'b0;
    while (beats <= exp_len && cyc < 200) begin
      ddr_if.wdata_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      frame_start = fs_pend;
      fs_pend = 1'b0;
      #1;
      if (held_v && (!ddr_if.wdata_valid || ddr_if.wdata != held)) hold_ok = 1'b0;
      held_v = 1'b0;
      if (ddr_if.wdata_valid) begin
        if (ddr_if.wdata_ready) begin
          if (ddr_if.wdata != mk_word(exp_seq)) data_ok = 1'b0;
          exp_seq++;
          if (ddr_if.wdata_last != (beats == exp_len)) last_ok = 1'b0;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          beats++;
          if (beats == fs_beat) fs_pend = 1'b1;
        end else begin
          held   = ddr_if.wdata;
          held_v = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    frame_start = 1'b0;
    ddr_if.wdata_ready = 1'b0;
    check("beat_count", 128'(beats), 128'(exp_len + 1));
    check("wdata_fifo_order", 128'(data_ok), 128'(1));
    check("wdata_last_pos", 128'(last_ok), 128'(1));
    if (toggle) check("wdata_hold_stable", 128'(hold_ok), 128'(1));
    else        check("full_rate_span", 128'(last_c - first_c), 128'(exp_len));
    check("idle_after_burst", 128'(busy), 128'(0));
    $display("burst addr=%0d len=%0d buf=%0d beats=%0d toggle=%0d", a0, l0, exp_buf, beats, toggle);
  endtask

  typedef struct {
    bit fs_before;
    int level;
    bit toggle;
    int cmd_delay;
    bit exp_cmd;
    int exp_addr;
    int exp_len;
    int exp_buf;
  } vec_t;

  vec_t vec [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{1'b0, 40, 1'b0, 0, 1'b1,  0, 15, 0};
    vec[1] = '{1'b0, 40, 1'b1, 3, 1'b1, 16, 15, 0};
    vec[2] = '{1'b0, 40, 1'b0, 0, 1'b1, 32,  7, 0};
    vec[3] = '{1'b0, 40, 1'b0, 0, 1'b0,  0,  0, 0};
    vec[4] = '{1'b1, 15, 1'b0, 0, 1'b0,  0,  0, 1};
    vec[5] = '{1'b0, 16, 1'b0, 0, 1'b1, 40, 15, 1};

    ddr_if.cmd_ready   = 1'b0;
    ddr_if.wdata_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_cmd_valid", 128'(ddr_if.cmd_valid), 128'(0));
    check("rst_wdata_valid", 128'(ddr_if.wdata_valid), 128'(0));
    check("rst_fifo_rd_en", 128'(fifo_rd_en), 128'(0));
    check("rst_buf_idx", 128'(buf_idx), 128'(0));
    check("rst_cmd_addr", 128'(ddr_if.cmd_addr), 128'(0));
    rst = 1'b0;

    // Two frame_starts with an empty FIFO: buffer 1, then abandon back to buffer 0.
    pulse_fs();
    check("fs1_buf_idx", 128'(buf_idx), 128'(1));
    pulse_fs();
    check("fs2_buf_idx", 128'(buf_idx), 128'(0));

    for (int i = 0; i < 6; i++) begin
      fifo_level = 12'(vec[i].level);
      if (vec[i].fs_before) pulse_fs();
      if (vec[i].exp_cmd)
        run_burst(vec[i].toggle, vec[i].cmd_delay, vec[i].exp_addr,
                  vec[i].exp_len, vec[i].exp_buf, 0);
      else
        expect_no_cmd(12, vec[i].exp_buf);
    end
    check("skid_occupancy_le2", 128'(occ_bad), 128'(0));

    // Abandon buffer 1 mid-frame, then frame_start arrives on beat 5 of a burst.
    fifo_level = 12'd0;
    pulse_fs();
    check("abandon_buf_idx", 128'(buf_idx), 128'(0));
    fifo_level = 12'd40;
    run_burst(1'b0, 0, 0, 15, 0, 5);
    run_burst(1'b0, 0, 40, 15, 1, 0);
`ifdef DDR_WR_BURST_STAT_EN
    check("burst_cnt", 128'(burst_cnt), 128'(6));
    check("frame_drop_cnt", 128'(drop_cnt), 128'(3));
`endif

    // Reset in the middle of a data phase.
    begin
      int w;
      w = 0;
      while (!ddr_if.cmd_valid && w < 50) begin
        tick();
        w++;
      end
      check("pre_rst_cmd_addr", 128'(ddr_if.cmd_addr), 128'(56));
      ddr_if.cmd_ready = 1'b1;
      tick();
      ddr_if.cmd_ready   = 1'b0;
      ddr_if.wdata_ready = 1'b1;
      repeat (5) tick();
      check("pre_rst_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      tick();
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_wdata_valid", 128'(ddr_if.wdata_valid), 128'(0));
      check("midrst_wdata", 128'(ddr_if.wdata), 128'(0));
      check("midrst_wdata_last", 128'(ddr_if.wdata_last), 128'(0));
      check("midrst_fifo_rd_en", 128'(fifo_rd_en), 128'(0));
      check("midrst_cmd_valid", 128'(ddr_if.cmd_valid), 128'(0));
      check("midrst_cmd_len", 128'(ddr_if.cmd_len), 128'(0));
      check("midrst_buf_idx", 128'(buf_idx), 128'(0));
`ifdef DDR_WR_BURST_STAT_EN
      check("midrst_burst_cnt", 128'(burst_cnt), 128'(0));
`endif
      $display("reset applied mid-burst");
      rst = 1'b0;
      ddr_if.wdata_ready = 1'b0;
      expect_no_cmd(10, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_ctrl.md
DDR_WR_BURST_CTRL -- requirements
Module: ddr_wr_burst_ctrl

Interface
REQ-001 Parameter BURST_LEN, default 16: maximum 128-bit words per DDR write burst (power of 2, 2..64).
REQ-002 Parameter FRAME_WORDS, default 115200: 128-bit words per video frame (1280x720x16b).
REQ-003 Parameter BASE_ADDR, default 28'h0: word address of frame buffer 0.
REQ-004 Parameter NUM_BUFS, default 2: frame buffers in rotation (1..4).
REQ-005 Port clk, input, 1: single clock, same clock as the FIFO read side and the DDR user port.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port frame_start, input, 1: one-cycle pulse marking a new input frame.
REQ-008 Port fifo_rd_water_level, input, 12: FIFO read-side fill level in words.
REQ-009 Port fifo_rd_empty, input, 1: FIFO empty.
REQ-010 Port fifo_rd_en, output, 1: FIFO read enable.
REQ-011 Port fifo_rd_data, input, 128: FIFO read data, valid the cycle after fifo_rd_en.
REQ-012 Port cmd_valid / cmd_ready, output / input, 1 each: burst command handshake.
REQ-013 Port cmd_addr, output, 28: burst start word address.
REQ-014 Port cmd_len, output, 7: burst length minus 1.
REQ-015 Port wdata_valid / wdata_ready, output / input, 1 each: write-data handshake.
REQ-016 Port wdata, output, 128: write data.
REQ-017 Port wdata_last, output, 1: final beat of the burst.
REQ-018 Port busy, output, 1: high in any state other than IDLE.
REQ-019 Port buf_idx, output, 2: buffer currently being written.

Function
REQ-020 FSM states and transitions:
- IDLE -> CMD when fifo_rd_water_level >= min(BURST_LEN, words_left) and words_left > 0.
- CMD -> DATA on cmd_valid && cmd_ready.
- DATA -> IDLE on the handshake of the beat with wdata_last.
REQ-021 In CMD:
- cmd_valid SHALL be held high, with cmd_addr and cmd_len stable, until cmd_ready.
- cmd_addr = BASE_ADDR + buf_idx*FRAME_WORDS + word_ofs.
REQ-022 Burst length SHALL be min(BURST_LEN, words_left).
- A short final burst covers any FRAME_WORDS remainder.
- No burst SHALL cross a frame end.
REQ-023 DATA SHALL use a 2-entry skid buffer to absorb the 1-cycle FIFO read latency.
- fifo_rd_en SHALL assert only when buffer occupancy plus in-flight reads < 2, beats requested < burst length, and !fifo_rd_empty.
REQ-024 wdata_valid SHALL be high whenever the skid buffer is non-empty in DATA.
- wdata SHALL be stable while wdata_valid && !wdata_ready.
- A full-rate beat per cycle SHALL be sustained when wdata_ready is constantly high.
REQ-025 wdata_last SHALL be high exactly on beat cmd_len.
REQ-026 On each completed burst, word_ofs += burst length.
- When word_ofs reaches FRAME_WORDS, words_left = 0 and the block SHALL idle until frame_start.
REQ-027 frame_start in IDLE: word_ofs <= 0, buf_idx <= (buf_idx+1) mod NUM_BUFS, effective next cycle.
REQ-028 frame_start during CMD or DATA SHALL be latched, and the current burst completes unchanged.
- The latched pulse is applied on return to IDLE; coincident latched and new pulses count as one.
REQ-029 frame_start while words_left > 0 SHALL abandon the remainder of the old frame; the FIFO is not drained.

Reset
REQ-030 On rst, next edge: state IDLE; all outputs 0; buf_idx 0; word_ofs 0; words_left 0; skid buffer empty; pending frame_start cleared.
REQ-031 rst mid-burst SHALL abort without completing handshakes; downstream is reset by the same rst.

Configuration
REQ-032 Macro DDR_WR_BURST_STAT_EN defined: adds output burst_cnt (16 bits) and output frame_drop (1 bit).
- burst_cnt increments on each wdata_last handshake and wraps at 16'hFFFF.
- frame_drop pulses for one cycle when REQ-029 applies.
REQ-033 Macro not defined: neither port nor its logic exists.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, CMD, DATA) and the DDR address and length width constants.
REQ-035 The skid buffer SHALL be the sub-module ddr_wr_skid_buf.
- 2 entries, 128-bit, with push/pop/count ports.

Verification
REQ-036 Defaults; level 16; cmd_ready and wdata_ready tied 1 -> one cmd at addr 0 with len 15; 16 beats on consecutive cycles; wdata_last on beat 16.
REQ-037 FRAME_WORDS=40, BURST_LEN=16, level held 40 -> three bursts: addr 0/16/32, cmd_len 15/15/7; then idle until frame_start.
REQ-038 wdata_ready toggled 1-0-1-0 -> no beat lost or duplicated; wdata sequence equals FIFO order; fifo_rd_en never raises skid occupancy above 2.
REQ-039 frame_start on beat 5 of a burst -> burst completes at its original address; next cmd_addr = FRAME_WORDS (buf_idx 1).
REQ-040 rst asserted during DATA -> next cycle all outputs 0 and state IDLE; with DDR_WR_BURST_STAT_EN, burst_cnt = 0.
